// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types for the elevator car controller:
//   state_t : controller states (IDLE, MOVE, DOOR)
//   dir_t   : travel direction memory (DN = 0, UP = 1)
//   max_int : helper used to size the shared travel/door timer
// -----------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } dir_t;

    // Larger of two integers, used for elaboration-time sizing
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// -----------------------------------------------------------------------------
// elevator_req_scan
// Purely combinational classifier of the pending-request bitmap relative to a
// probe floor. The controller uses one copy on the current floor and one on the
// floor the car is about to step onto.
// Ports:
//   pending   in  NUM_FLOORS  bitmap of outstanding requests
//   cf        in  FLOOR_W     probe floor
//   any_above out 1           a request exists strictly above cf
//   any_below out 1           a request exists strictly below cf
//   at_floor  out 1           a request exists exactly at cf
// -----------------------------------------------------------------------------
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cf,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  at_floor
);

    // Sort every pending bit into above / below / at the probe floor
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        at_floor  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(cf)) begin
                any_above = any_above | pending[i];
            end else if (i < int'(cf)) begin
                any_below = any_below | pending[i];
            end else begin
                at_floor = pending[i];
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_ctrl
// Elevator car controller with a pending-request bitmap and SCAN scheduling:
// the car keeps its direction while requests remain beyond it, stops at every
// requested floor on the way, and only reverses from IDLE.
// Ports:
//   clk        in  1           system clock, rising edge
//   rst        in  1           asynchronous active-low reset
//   req_valid  in  1           call request present this cycle
//   req_floor  in  FLOOR_W     requested floor (dropped if >= NUM_FLOORS)
//   cf         out FLOOR_W     current floor of the car
//   dir_up     out 1           1 = travelling/preferring up, 0 = down
//   moving     out 1           car is in MOVE
//   door_open  out 1           car is in DOOR
//   pending    out NUM_FLOORS  outstanding request bitmap
// -----------------------------------------------------------------------------
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic [FLOOR_W-1:0]    cf,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    // One timer serves both travel and door phases, so size it for the longer
    localparam int TIMER_W = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] TRAVEL_RELOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_RELOAD   = TIMER_W'(DOOR_CYCLES - 1);

    // One-hot mask for a floor index
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (int'(f) == i);
        end
        return m;
    endfunction

    state_t                state_q,   state_d;
    logic [TIMER_W-1:0]    timer_q,   timer_d;
    logic [FLOOR_W-1:0]    cf_q,      cf_d;
    dir_t                  dir_q,     dir_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  moving_q,  moving_d;
    logic                  door_q,    door_d;

    logic                  req_in_range_s;
    logic                  door_hold_s;
    logic [NUM_FLOORS-1:0] req_set_s;
    logic [NUM_FLOORS-1:0] clr_s;
    logic [FLOOR_W-1:0]    cf_step_s;
    logic                  cur_above_s, cur_below_s, cur_at_s;
    logic                  nxt_above_s, nxt_below_s, nxt_at_s;

    assign req_in_range_s = req_valid && (int'(req_floor) < NUM_FLOORS);
    // A call for the floor whose door is already open only extends the door time
    assign door_hold_s    = req_valid && (state_q == DOOR) && (req_floor == cf_q);
    assign req_set_s      = (req_in_range_s && !door_hold_s) ? floor_mask(req_floor)
                                                             : {NUM_FLOORS{1'b0}};
    // Floor the car lands on when the current travel step completes
    assign cf_step_s      = (dir_q == UP) ? (cf_q + FLOOR_W'(1)) : (cf_q - FLOOR_W'(1));

    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_cur (
        .pending   (pending_q),
        .cf        (cf_q),
        .any_above (cur_above_s),
        .any_below (cur_below_s),
        .at_floor  (cur_at_s)
    );

    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_nxt (
        .pending   (pending_q),
        .cf        (cf_step_s),
        .any_above (nxt_above_s),
        .any_below (nxt_below_s),
        .at_floor  (nxt_at_s)
    );

    // Next-state, timer, floor, direction and service-clear decisions
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cf_d    = cf_q;
        dir_d   = dir_q;
        clr_s   = {NUM_FLOORS{1'b0}};
        case (state_q)
            IDLE: begin
                if (cur_at_s) begin
                    state_d = DOOR;
                    timer_d = DOOR_RELOAD;
                    clr_s   = floor_mask(cf_q);
                end else if (((dir_q == UP) && cur_above_s) || ((dir_q == DN) && cur_below_s)) begin
                    state_d = MOVE;
                    timer_d = TRAVEL_RELOAD;
                end else if (cur_above_s || cur_below_s) begin
                    // Only work behind the car remains: reverse before moving
                    dir_d   = (dir_q == UP) ? DN : UP;
                    state_d = MOVE;
                    timer_d = TRAVEL_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (timer_q != {TIMER_W{1'b0}}) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    cf_d = cf_step_s;
                    if (nxt_at_s) begin
                        state_d = DOOR;
                        timer_d = DOOR_RELOAD;
                        clr_s   = floor_mask(cf_step_s);
                    end else if ((dir_q == UP) ? nxt_above_s : nxt_below_s) begin
                        state_d = MOVE;
                        timer_d = TRAVEL_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR: begin
                if (door_hold_s) begin
                    timer_d = DOOR_RELOAD;
                end else if (timer_q == {TIMER_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = {TIMER_W{1'b0}};
            end
        endcase
    end

    // Request bitmap update (service clear overrides a same-cycle set) and output decode
    always_comb begin
        pending_d = (pending_q | req_set_s) & ~clr_s;
        moving_d  = (state_d == MOVE);
        door_d    = (state_d == DOOR);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= {TIMER_W{1'b0}};
            cf_q      <= {FLOOR_W{1'b0}};
            dir_q     <= UP;
            pending_q <= {NUM_FLOORS{1'b0}};
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cf_q      <= cf_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            moving_q  <= moving_d;
            door_q    <= door_d;
        end
    end

    assign cf        = cf_q;
    assign dir_up    = (dir_q == UP);
    assign moving    = moving_q;
    assign door_open = door_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_ctrl
// Directed bench for elevator_ctrl: a 4-floor instance for the main scenarios
// and a 5-floor instance for out-of-range requests and the top-floor bound.
// -----------------------------------------------------------------------------
module tb_elevator_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_floor;
    logic [1:0] cf;
    logic       dir_up, moving, door_open;
    logic [3:0] pending;

    logic       req_valid5;
    logic [2:0] req_floor5;
    logic [2:0] cf5;
    logic       dir_up5, moving5, door_open5;
    logic [4:0] pending5;

    int n_asserts;
    int n_fail;

    elevator_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .cf        (cf),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    elevator_ctrl #(.NUM_FLOORS(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid5),
        .req_floor (req_floor5),
        .cf        (cf5),
        .dir_up    (dir_up5),
        .moving    (moving5),
        .door_open (door_open5),
        .pending   (pending5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request to the 4-floor car for exactly one edge
    task automatic req4(input logic [1:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick(1);
        req_valid = 1'b0;
    endtask

    // Present a request to the 5-floor car for exactly one edge
    task automatic req5(input logic [2:0] f);
        req_valid5 = 1'b1;
        req_floor5 = f;
        tick(1);
        req_valid5 = 1'b0;
    endtask

    initial begin
        n_asserts  = 0;
        n_fail     = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_floor  = 2'd0;
        req_valid5 = 1'b0;
        req_floor5 = 3'd0;

        // Reset values
        tick(3);
        chk("rst_cf",      32'(cf),        32'd0);
        chk("rst_dir",     32'(dir_up),    32'd1);
        chk("rst_moving",  32'(moving),    32'd0);
        chk("rst_door",    32'(door_open), 32'd0);
        chk("rst_pending", 32'(pending),   32'd0);
        chk("rst_cf5",     32'(cf5),       32'd0);
        rst = 1'b1;
        tick(5);
        chk("idle_cf",      32'(cf),        32'd0);
        chk("idle_moving",  32'(moving),    32'd0);
        chk("idle_door",    32'(door_open), 32'd0);
        chk("idle_pending", 32'(pending),   32'd0);

        // Call at current floor, then door hold
        req4(2'd0);
        chk("d_pend_set",  32'(pending),   32'h1);
        chk("d_door_e1",   32'(door_open), 32'd0);
        tick(1);
        chk("d_door_open", 32'(door_open), 32'd1);
        chk("d_pend_clr",  32'(pending),   32'd0);
        chk("d_no_move",   32'(moving),    32'd0);
        req4(2'd0);
        chk("d_hold_door", 32'(door_open), 32'd1);
        chk("d_hold_nq",   32'(pending),   32'd0);
        tick(2);
        chk("d_held_open", 32'(door_open), 32'd1);
        tick(1);
        chk("d_closed",    32'(door_open), 32'd0);
        chk("d_cf",        32'(cf),        32'd0);

        // Travel 0 -> 3
        req4(2'd3);
        chk("b_pend",     32'(pending),   32'h8);
        chk("b_moving0",  32'(moving),    32'd0);
        tick(1);
        chk("b_moving1",  32'(moving),    32'd1);
        chk("b_dir",      32'(dir_up),    32'd1);
        tick(3);
        chk("b_cf_e5",    32'(cf),        32'd0);
        tick(1);
        chk("b_cf1",      32'(cf),        32'd1);
        tick(4);
        chk("b_cf2",      32'(cf),        32'd2);
        tick(4);
        chk("b_cf3",      32'(cf),        32'd3);
        chk("b_door",     32'(door_open), 32'd1);
        chk("b_stopped",  32'(moving),    32'd0);
        chk("b_pend0",    32'(pending),   32'd0);
        tick(2);
        chk("b_door_e16", 32'(door_open), 32'd1);
        tick(1);
        chk("b_door_cl",  32'(door_open), 32'd0);
        chk("b_idle",     32'(moving),    32'd0);

        // Reverse toward 0, then async reset mid-MOVE
        req4(2'd0);
        tick(1);
        chk("r_dir_flip", 32'(dir_up),    32'd0);
        chk("r_moving",   32'(moving),    32'd1);
        tick(4);
        chk("r_cf2",      32'(cf),        32'd2);
        rst = 1'b0;
        #1;
        chk("r_async_cf",   32'(cf),        32'd0);
        chk("r_async_dir",  32'(dir_up),    32'd1);
        chk("r_async_mov",  32'(moving),    32'd0);
        chk("r_async_door", 32'(door_open), 32'd0);
        chk("r_async_pend", 32'(pending),   32'd0);
        tick(1);
        rst = 1'b1;
        tick(2);
        chk("r_after_mov", 32'(moving), 32'd0);

        // Intermediate stop at 1, up to 3, back down to 0
        req4(2'd3);
        tick(1);
        chk("c_moving",   32'(moving),    32'd1);
        req4(2'd1);
        req4(2'd0);
        chk("c_pend",     32'(pending),   32'hB);
        tick(2);
        chk("c_cf1",      32'(cf),        32'd1);
        chk("c_door1",    32'(door_open), 32'd1);
        chk("c_pend1",    32'(pending),   32'h9);
        tick(3);
        chk("c_idle1",    32'(door_open | moving), 32'd0);
        tick(1);
        chk("c_mov_up",   32'(moving),    32'd1);
        chk("c_dir_up",   32'(dir_up),    32'd1);
        tick(8);
        chk("c_cf3",      32'(cf),        32'd3);
        chk("c_door3",    32'(door_open), 32'd1);
        chk("c_pend3",    32'(pending),   32'h1);
        tick(4);
        chk("c_mov_dn",   32'(moving),    32'd1);
        chk("c_dir_dn",   32'(dir_up),    32'd0);
        tick(12);
        chk("c_cf0",      32'(cf),        32'd0);
        chk("c_door0",    32'(door_open), 32'd1);
        chk("c_pend0",    32'(pending),   32'd0);
        tick(3);
        chk("c_done",     32'(door_open | moving), 32'd0);

        // Repeat request on the arrival edge at floor 2
        req4(2'd2);
        tick(1);
        chk("f_dir_flip", 32'(dir_up),    32'd1);
        chk("f_moving",   32'(moving),    32'd1);
        tick(7);
        chk("f_cf1",      32'(cf),        32'd1);
        chk("f_pend",     32'(pending),   32'h4);
        req4(2'd2);
        chk("f_cf2",      32'(cf),        32'd2);
        chk("f_door",     32'(door_open), 32'd1);
        chk("f_pend_clr", 32'(pending),   32'd0);
        tick(3);
        chk("f_closed",   32'(door_open), 32'd0);
        tick(2);
        chk("f_single",   32'(door_open | moving), 32'd0);
        chk("f_pend_end", 32'(pending),   32'd0);
        chk("f_cf_end",   32'(cf),        32'd2);

        // Five floors: out-of-range drop and top-floor bound
        req5(3'd6);
        chk("o_pend_drop", 32'(pending5), 32'd0);
        tick(2);
        chk("o_no_move",   32'(moving5),  32'd0);
        chk("o_cf",        32'(cf5),      32'd0);
        req5(3'd4);
        chk("o_pend4",     32'(pending5), 32'h10);
        tick(1);
        chk("o_moving",    32'(moving5),  32'd1);
        tick(16);
        chk("o_cf4",       32'(cf5),        32'd4);
        chk("o_door4",     32'(door_open5), 32'd1);
        chk("o_pend_clr",  32'(pending5),   32'd0);
        chk("o_dir",       32'(dir_up5),    32'd1);
        tick(3);
        chk("o_closed",    32'(door_open5), 32'd0);
        tick(5);
        chk("o_cf_bound",  32'(cf5),     32'd4);
        chk("o_parked",    32'(moving5), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
Parametrised elevator car controller for N floors, with multi-request queueing and SCAN (keep-direction) scheduling. It accepts floor call requests, holds them in a pending bitmap, and moves the car one floor per TRAVEL_CYCLES. It stops to open the door at every requested floor. It supersedes the fixed 2-bit, 4-floor controller, adding a request queue, direction memory, timed travel and timed door, and sits between the call-button decoder and the motor/door drivers.

Parameters:
NUM_FLOORS, 4, number of floors (>=2); floors are numbered 0..NUM_FLOORS-1.
FLOOR_W, $clog2(NUM_FLOORS), width of floor indices (derived; do not override).
TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
DOOR_CYCLES, 3, clock cycles the door stays open (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  a call request is present this cycle.
req_floor  in  FLOOR_W  requested floor; ignored if >= NUM_FLOORS.
cf  out  FLOOR_W  current floor of the car.
dir_up  out  1  1 = travelling/preferring up, 0 = down.
moving  out  1  1 while the car is in the MOVE state.
door_open  out  1  1 while the car is in the DOOR state.
pending  out  NUM_FLOORS  bitmap of outstanding requests.

Behaviour:
- All outputs are registered. Reset (rst=0, async) values: cf=0, dir_up=1, moving=0, door_open=0, pending=0, state=IDLE, timer=0.
- Request capture: when req_valid=1 and req_floor<NUM_FLOORS, pending[req_floor] is set at the next edge. Out-of-range requests are dropped. Duplicate requests have no effect.
- The FSM has three states, IDLE, MOVE and DOOR, with a down-counting timer.
- IDLE (moving=0, door_open=0):
  - If pending[cf]=1: go to DOOR, clear pending[cf], timer=DOOR_CYCLES-1.
  - Else if a request exists in the dir_up direction: go to MOVE, keep dir, timer=TRAVEL_CYCLES-1.
  - Else if a request exists in the opposite direction: flip dir_up, go to MOVE, timer=TRAVEL_CYCLES-1.
  - Else stay in IDLE.
- MOVE (moving=1):
  - While timer>0, decrement.
  - At timer==0, cf steps to cf+1 (dir_up=1) or cf-1 (dir_up=0) on the same edge.
  - If pending[new cf]=1: go to DOOR, clear that bit, timer=DOOR_CYCLES-1.
  - Else if requests remain beyond new cf in the current direction: stay in MOVE, timer=TRAVEL_CYCLES-1.
  - Else go to IDLE.
- DOOR (door_open=1):
  - A request for cf arriving in this state is not queued; it reloads timer=DOOR_CYCLES-1 (door hold).
  - At timer==0, go to IDLE.
- Latency: a request for floor k>cf arriving at cycle t while IDLE sets pending at t+1, enters MOVE at t+2, and reaches k after (k-cf)*TRAVEL_CYCLES further cycles. The door opens on the arrival edge.
- Bounds: the car never moves below 0 or above NUM_FLOORS-1; a direction is only chosen if a request exists strictly beyond cf in that direction.
- Same-cycle set and clear of one bit: the clear wins; that floor is being serviced.
- dir_up is retained across IDLE; it only flips per the IDLE rule above.
- An asynchronous reset mid-MOVE or mid-DOOR immediately returns all state to reset values and discards pending requests.

Decomposition:
- Shared package elevator_pkg holds the state_t enum (IDLE, MOVE, DOOR) and the dir_t typedef (DN=0, UP=1).
- One combinational sub-module, elevator_req_scan, takes (pending, cf) and produces any_above, any_below and at_floor. It is instantiated twice: once on the current cf for IDLE decisions, once on the next cf for MOVE-arrival decisions.

Test Plan:
(All scenarios use defaults: NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3.)
- Reset hold then release, no requests -> cf=0, dir_up=1, all other outputs 0, state IDLE indefinitely. Assert rst=0 mid-MOVE -> outputs return to reset values on the same cycle.
- Request floor 3 from cf=0 at cycle t:
  - pending=4'b1000 at t+1 and moving=1 at t+2.
  - cf goes 1, 2, 3 every 4 cycles; door_open=1 for 3 cycles at floor 3.
  - Then IDLE with pending=0.
- While moving up from 0 toward 3, request floor 1 (before arrival at 1) and floor 0 -> car stops at 1 (door 3 cycles), continues to 3, then flips dir_up=0 and returns to 0.
- Request floor 0 while IDLE at cf=0 -> door_open=1 for 3 cycles, no movement. Repeat the request during DOOR -> door stays open 3 cycles past the last request.
- Out-of-range check: parametrise NUM_FLOORS=5 (FLOOR_W=3), request floor 6 -> pending unchanged, no movement. Request floor 4 -> car reaches cf=4 and does not exceed it.
- Simultaneous req_valid for floor 2 on the cycle the car arrives at floor 2 in MOVE -> pending[2] ends 0, door_open=1, single stop.
